// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - IF-stage PC sequencer with stall, branch/jump redirect and ROM-window halt
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 64,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jmp_en,
    input  logic [25:0]      jmp_tgt,
    input  logic             br_en,
    input  logic [31:0]      br_tgt,
    input  logic             halt_req,
    output logic [31:0]      rom_addr,
    input  logic [31:0]      rom_inst,
    output logic [31:0]      ifid_pc,
    output logic [31:0]      ifid_inst,
    output logic             ifid_valid,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] jmp_pc;
    logic        in_range;

    assign rom_addr = pc;
    assign jmp_pc   = {pc[31:28], jmp_tgt, 2'b00};
    // Range check happens at capture time, so redirect targets are never rejected early.
    assign in_range = ({2'b00, pc[31:2]} < ROM_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_PC;
            ifid_pc    <= 32'h0;
            ifid_inst  <= 32'h0;
            ifid_valid <= 1'b0;
            halted     <= 1'b0;
            fetch_cnt  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    // Branch beats jump: it was resolved in EX, so it belongs to an older instruction.
                    if (br_en) begin
                        pc         <= br_tgt;
                        ifid_valid <= 1'b0;
                        ifid_inst  <= 32'h0;
                    end else if (jmp_en) begin
                        pc         <= jmp_pc;
                        ifid_valid <= 1'b0;
                        ifid_inst  <= 32'h0;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (halt_req || !in_range) begin
                        state      <= HALT;
                        halted     <= 1'b1;
                        ifid_valid <= 1'b0;
                        ifid_inst  <= 32'h0;
                    end else begin
                        ifid_inst  <= rom_inst;
                        ifid_pc    <= pc;
                        ifid_valid <= 1'b1;
                        pc         <= pc + 32'd4;
                        fetch_cnt  <= fetch_cnt + CNT_W'(1);
                    end
                end
                HALT: begin
                    ifid_valid <= 1'b0;
                    ifid_inst  <= 32'h0;
                    if (br_en) begin
                        pc     <= br_tgt;
                        state  <= RUN;
                        halted <= 1'b0;
                    end else if (jmp_en) begin
                        pc     <= jmp_pc;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - scoreboard bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        jmp_en;
    logic [25:0] jmp_tgt;
    logic        br_en;
    logic [31:0] br_tgt;
    logic        halt_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_inst;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_cnt;

    logic [31:0] rom [64];
    logic [63:0] sb_q [$];
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;
    logic [63:0] exp_cap;
    int          checks = 0;
    int          errors = 0;

    inst_fetch_ctrl #(.RESET_PC(32'h0), .ROM_WORDS(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jmp_en(jmp_en), .jmp_tgt(jmp_tgt),
        .br_en(br_en), .br_tgt(br_tgt), .halt_req(halt_req), .rom_addr(rom_addr),
        .rom_inst(rom_inst), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
        .ifid_valid(ifid_valid), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    always_comb rom_inst = rom[rom_addr[7:2]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One normal fetch: expected capture is pushed before the edge, popped after.
    task automatic cap_step(input string tag);
        sb_q.push_back({exp_pc, rom[exp_pc[7:2]]});
        tick();
        exp_cap = sb_q.pop_front();
        exp_pc  = exp_pc + 32'd4;
        exp_cnt = exp_cnt + 16'd1;
        checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL %s valid got %b exp 1", tag, ifid_valid); end
        checks++; if (ifid_pc !== exp_cap[63:32]) begin errors++; $display("FAIL %s ifid_pc got %h exp %h", tag, ifid_pc, exp_cap[63:32]); end
        checks++; if (ifid_inst !== exp_cap[31:0]) begin errors++; $display("FAIL %s ifid_inst got %h exp %h", tag, ifid_inst, exp_cap[31:0]); end
        checks++; if (rom_addr !== exp_pc) begin errors++; $display("FAIL %s pc got %h exp %h", tag, rom_addr, exp_pc); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL %s fetch_cnt got %0d exp %0d", tag, fetch_cnt, exp_cnt); end
    endtask

    task automatic check_squash(input string tag, input logic [31:0] pc_exp, input logic halt_exp);
        checks++; if (rom_addr !== pc_exp) begin errors++; $display("FAIL %s pc got %h exp %h", tag, rom_addr, pc_exp); end
        checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL %s valid got %b exp 0", tag, ifid_valid); end
        checks++; if (ifid_inst !== 32'h0) begin errors++; $display("FAIL %s inst got %h exp 0", tag, ifid_inst); end
        checks++; if (halted !== halt_exp) begin errors++; $display("FAIL %s halted got %b exp %b", tag, halted, halt_exp); end
        checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL %s fetch_cnt got %0d exp %0d", tag, fetch_cnt, exp_cnt); end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 0; jmp_en = 0; jmp_tgt = '0; br_en = 0; br_tgt = '0; halt_req = 0;
        tick(); tick();
        exp_pc = 32'h0; exp_cnt = 16'd0;
        check_squash("reset", 32'h0, 1'b0);
        checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset ifid_pc got %h exp 0", ifid_pc); end
        rst = 1'b0;
        tick();
        check_squash("boot", 32'h0, 1'b0);
    endtask

    task automatic test_run();
        cap_step("run0");
        cap_step("run1");
        checks++; if (fetch_cnt !== 16'd2) begin errors++; $display("FAIL run_cnt got %0d exp 2", fetch_cnt); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rom_addr !== 32'h8) begin errors++; $display("FAIL stall_pc got %h exp 8", rom_addr); end
            checks++; if (ifid_pc !== 32'h4 || ifid_inst !== 32'h04201422 || ifid_valid !== 1'b1)
                begin errors++; $display("FAIL stall_ifid got %h/%h/%b exp 4/04201422/1", ifid_pc, ifid_inst, ifid_valid); end
            checks++; if (fetch_cnt !== exp_cnt) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", fetch_cnt, exp_cnt); end
        end
        stall = 1'b0;
        cap_step("post_stall");
    endtask

    task automatic test_jump();
        for (int i = 0; i < 4; i++) cap_step("to_1c");
        jmp_en = 1'b1; jmp_tgt = 26'd8;
        tick();
        jmp_en = 1'b0;
        exp_pc = 32'h20;
        check_squash("jump", 32'h20, 1'b0);
        cap_step("jump_tgt");
    endtask

    task automatic test_redirect_priority();
        br_en = 1'b1; br_tgt = 32'h10; jmp_en = 1'b1; jmp_tgt = 26'd8; stall = 1'b1;
        tick();
        br_en = 1'b0; jmp_en = 1'b0; stall = 1'b0;
        exp_pc = 32'h10;
        check_squash("br_over_jmp", 32'h10, 1'b0);
        cap_step("br_tgt");
    endtask

    task automatic test_halt_req();
        halt_req = 1'b1;
        tick();
        check_squash("halt_req", 32'h14, 1'b1);
        tick();
        halt_req = 1'b0;
        tick();
        check_squash("halt_hold", 32'h14, 1'b1);
        br_en = 1'b1; br_tgt = 32'h14;
        tick();
        br_en = 1'b0;
        check_squash("halt_exit_br", 32'h14, 1'b0);
        cap_step("after_halt");
    endtask

    task automatic test_out_of_range();
        jmp_en = 1'b1; jmp_tgt = 26'd63;
        tick();
        jmp_en = 1'b0;
        exp_pc = 32'hFC;
        check_squash("jmp_63", 32'hFC, 1'b0);
        cap_step("word63");
        tick();
        check_squash("oor_halt", 32'h100, 1'b1);
        tick();
        check_squash("oor_hold", 32'h100, 1'b1);
        jmp_en = 1'b1; jmp_tgt = 26'd0;
        tick();
        jmp_en = 1'b0;
        exp_pc = 32'h0;
        check_squash("oor_exit", 32'h0, 1'b0);
        cap_step("oor_resume");
    endtask

    task automatic test_reset_mid_stall();
        jmp_en = 1'b1; jmp_tgt = 26'd5;
        tick();
        jmp_en = 1'b0; stall = 1'b1;
        tick();
        checks++; if (rom_addr !== 32'h14) begin errors++; $display("FAIL pre_rst_pc got %h exp 14", rom_addr); end
        rst = 1'b1;
        tick();
        rst = 1'b0; stall = 1'b0;
        exp_pc = 32'h0; exp_cnt = 16'd0;
        check_squash("rst_mid_stall", 32'h0, 1'b0);
        tick();
        check_squash("reboot", 32'h0, 1'b0);
        cap_step("reboot_run");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
        rom[0] = 32'h0;
        rom[1] = 32'h04201422;
        rom[8] = 32'h14000464;
        test_reset();
        test_run();
        test_stall();
        test_jump();
        test_redirect_priority();
        test_halt_req();
        test_out_of_range();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
